sorted_muon_serializer: RTL

- Sits directly downstream of the retimed bitonic sorter.
- Captures one sorted muon array per frame, keeps the top NOUT candidates and streams them out BEAT muons per cycle over a valid/ready handshake.
- Feeds the narrow serial link toward the next trigger processing stage.
- Holds its own frame buffer, so the sorter output only needs to be valid for the single accept cycle.

---
 rtl/bitonic_sorter_pkg.sv | 25 ++
 rtl/muon_frame_buffer.sv | 49 ++++
 rtl/sorted_muon_serializer.sv | 103 ++++++++++
 3 files changed

// File: rtl/bitonic_sorter_pkg.sv
// Shared types for the muon sorter chain: the muon record, the serializer
// state enum and the beat-count helper used by the optional zero-skip build.
package bitonic_sorter_pkg;

  localparam int PT_W = 8;

  typedef struct packed {
    logic [PT_W-1:0] pt;
    logic [7:0]      eta;
    logic [7:0]      phi;
  } muon_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Beats needed to carry 'count' candidates, never fewer than one.
  function automatic int beats_needed(input int count, input int beat);
    int n;
    n = (count + beat - 1) / beat;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/muon_frame_buffer.sv
// One-frame store for the serializer: captures the top NOUT muons highest-pt
// first (reversing an ascending sorter) and presents the selected beat.
module muon_frame_buffer
  import bitonic_sorter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NOUT  = 8,
  parameter int BEAT  = 2,
  parameter int DIR   = 1,
  parameter int IDXW  = $clog2(NOUT / BEAT) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  muon_t [0:WIDTH-1]     m,
  input  logic [IDXW-1:0]       beat_idx,
  output muon_t [0:BEAT-1]      beat_data
);

  localparam int NBEATS = NOUT / BEAT;

  muon_t [0:NOUT-1] store;
  logic             unused_m;

  // Candidates below the top NOUT are deliberately dropped.
  assign unused_m = ^m;

  always_ff @(posedge clk) begin
    if (rst) begin
      store <= '0;
    end else if (load) begin
      for (int i = 0; i < NOUT; i++) begin
        store[i] <= (DIR != 0) ? m[i] : m[WIDTH-1-i];
      end
    end
  end

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < NBEATS; b++) begin
      if (beat_idx == IDXW'(b)) begin
        for (int j = 0; j < BEAT; j++) begin
          beat_data[j] = store[b*BEAT + j];
        end
      end
    end
  end

endmodule

// File: rtl/sorted_muon_serializer.sv
// Streams the top NOUT muons of each sorted frame out BEAT at a time.
// Define SORTED_MUON_SERIALIZER_ZERO_SKIP_EN to end frames after the last non-empty beat.
module sorted_muon_serializer
  import bitonic_sorter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NOUT  = 8,
  parameter int BEAT  = 2,
  parameter int DIR   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  muon_t [0:WIDTH-1]            m,
  output logic                         out_valid,
  input  logic                         out_ready,
  output muon_t [0:BEAT-1]             out_data,
  output logic                         out_last,
  output logic [$clog2(NOUT/BEAT):0]   out_beat_idx,
  output logic [15:0]                  frame_cnt
);

  localparam int NBEATS = NOUT / BEAT;
  localparam int IDXW   = $clog2(NBEATS) + 1;

  ser_state_t      state, state_nxt;
  logic [IDXW-1:0] beat_idx, last_idx, cap_last;
  logic            beat_xfer, load;

`ifdef SORTED_MUON_SERIALIZER_ZERO_SKIP_EN
  int nz_cnt;

  // Empty slots (pt==0) sort to the tail, so the frame can stop early.
  always_comb begin
    nz_cnt = 0;
    for (int i = 0; i < NOUT; i++) begin
      if (m[(DIR != 0) ? i : WIDTH-1-i].pt != '0) nz_cnt = nz_cnt + 1;
    end
    cap_last = IDXW'(beats_needed(nz_cnt, BEAT) - 1);
  end
`else
  assign cap_last = IDXW'(NBEATS - 1);
`endif

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = (beat_idx == last_idx);
        // Releasing the buffer on the last transfer lets frames run back-to-back.
        if (out_ready && out_last) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? SEND : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    beat_xfer = out_valid & out_ready;
    load      = in_valid & in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_idx  <= '0;
      last_idx  <= IDXW'(NBEATS - 1);
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load || (beat_xfer && out_last)) beat_idx <= '0;
      else if (beat_xfer)                  beat_idx <= beat_idx + IDXW'(1);
      if (load) last_idx <= cap_last;
      if (beat_xfer && out_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign out_beat_idx = beat_idx;

  muon_frame_buffer #(
    .WIDTH (WIDTH),
    .NOUT  (NOUT),
    .BEAT  (BEAT),
    .DIR   (DIR),
    .IDXW  (IDXW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .m         (m),
    .beat_idx  (beat_idx),
    .beat_data (out_data)
  );

endmodule
